// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry, flush, bubble fill and stall counter
module pipe_stage_reg #(
    parameter int unsigned          DW     = 64,
    parameter logic [DW-1:0]        BUBBLE = '0,
    parameter bit                   SKID   = 1'b1,
    parameter int unsigned          CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    main_q, main_d;
    logic [DW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc, dep;

    // outputs are a pure function of state; in_ready only sees out_ready when there is no skid entry
    always_comb begin
        out_valid_o = state_q != EMPTY;
        out_data_o  = main_q;
        occupancy_o = state_q;
        stall_cnt_o = cnt_q;
        in_ready_o  = !rst && !flush_i && (SKID ? state_q != FULL : (state_q == EMPTY || out_ready_i));
        acc         = in_valid_i && in_ready_o;
        dep         = out_valid_o && out_ready_i;
    end

    // next-state: flush empties everything, otherwise move entries according to accept/depart
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data_i;
                    end
                end
                ONE: begin
                    if (acc && dep) begin
                        main_d = in_data_i;
                    end else if (dep) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end else if (acc && SKID) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                    end
                end
                FULL: begin
                    if (dep) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
        cnt_d = (out_valid_o && !out_ready_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // state register with synchronous reset to the bubble-filled empty state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of skid and non-skid pipe_stage_reg instances
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready, in_ready, out_valid;
    logic [7:0] in_data, out_data;
    logic [1:0] occ;
    logic [2:0] cnt;
    logic       b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [7:0] b_in_data, b_out_data, b_cnt;
    logic [1:0] b_occ;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DW(8), .BUBBLE(8'h13), .SKID(1'b1), .CNT_W(3)) u_a (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occupancy_o(occ), .stall_cnt_o(cnt)
    );

    pipe_stage_reg #(.DW(8), .BUBBLE(8'h13), .SKID(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .flush_i(1'b0),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .occupancy_o(b_occ), .stall_cnt_o(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = 0;
        b_in_valid = 0; b_out_ready = 0; b_in_data = 0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h13);
        chk("rst_occ", occ, 0);
        chk("rst_cnt", cnt, 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1; in_data = 8'(i);
            tick();
            chk("stream_data", out_data, i);
            chk("stream_occ", occ, 1);
        end
        in_valid = 0;
        tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_data", out_data, 8'h13);
        chk("stream_cnt", cnt, 0);

        out_ready = 0; in_valid = 1; in_data = 8'hA1;
        tick();
        in_data = 8'hA2;
        tick();
        in_valid = 0;
        chk("skid_occ", occ, 2);
        chk("skid_in_ready", in_ready, 0);
        chk("skid_head", out_data, 8'hA1);
        chk("skid_cnt", cnt, 1);
        out_ready = 1;
        tick();
        chk("drain_a2", out_data, 8'hA2);
        chk("drain_occ1", occ, 1);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_bubble", out_data, 8'h13);

        out_ready = 0; in_valid = 1; in_data = 8'hA3;
        tick();
        in_data = 8'hA4;
        tick();
        chk("pre_flush_occ", occ, 2);
        chk("pre_flush_cnt", cnt, 2);
        flush = 1; out_ready = 1; in_data = 8'hFF;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0;
        chk("flush_occ", occ, 0);
        chk("flush_data", out_data, 8'h13);
        chk("flush_cnt", cnt, 2);
        tick();
        chk("flush_no_ff", out_data, 8'h13);
        chk("flush_no_valid", out_valid, 0);

        rst = 1;
        tick();
        rst = 0;
        chk("rst2_cnt", cnt, 0);
        out_ready = 0; in_valid = 1; in_data = 8'h5A;
        tick();
        in_valid = 0;
        chk("sat_start", cnt, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("sat_cnt", cnt, (k < 7) ? k : 7);
            chk("sat_data", out_data, 8'h5A);
        end
        rst = 1;
        tick();
        chk("rst3_cnt", cnt, 0);
        chk("rst3_occ", occ, 0);
        rst = 0;

        #1;
        chk("b_empty_ready", b_in_ready, 1);
        b_in_valid = 1; b_in_data = 8'h31;
        tick();
        chk("b_occ1", b_occ, 1);
        chk("b_data31", b_out_data, 8'h31);
        b_in_data = 8'h32;
        #1;
        chk("b_stall_ready", b_in_ready, 0);
        tick();
        chk("b_stall_occ", b_occ, 1);
        chk("b_stall_data", b_out_data, 8'h31);
        b_out_ready = 1;
        #1;
        chk("b_pass_ready", b_in_ready, 1);
        tick();
        chk("b_data32", b_out_data, 8'h32);
        chk("b_occ_b2b", b_occ, 1);
        b_in_data = 8'h33;
        tick();
        chk("b_data33", b_out_data, 8'h33);
        b_in_valid = 0;
        tick();
        chk("b_empty_data", b_out_data, 8'h13);
        chk("b_empty_occ", b_occ, 0);
        chk("b_cnt", b_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
